// File: rtl/fifo_tx_drain.sv
// fifo_tx_drain: pops words from a FIFO while pndng is high and sends each one
// as a serial frame: start bit, data LSB first, optional even parity, stop bit.
module fifo_tx_drain #(
    parameter int bits         = 8,
    parameter int clks_per_bit = 4,
    parameter bit parity_en    = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pndng,
    input  logic [bits-1:0] fifo_dout,
    output logic            pop,
    output logic            tx,
    output logic            busy,
    output logic            frame_done
);
    localparam int BW = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    localparam int CW = $clog2(bits + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(clks_per_bit - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(bits - 1);

    typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, PARITY, STOP} state_t;

    state_t          state, next;
    logic [BW-1:0]   baud;
    logic [CW-1:0]   cnt;
    logic [bits-1:0] shreg;
    logic            par;
    logic            bit_end;

    assign bit_end = baud == BAUD_LAST;

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = pndng ? POP : IDLE;
            POP:     next = LOAD;
            LOAD:    next = START;
            START:   next = bit_end ? DATA : START;
            DATA:    if (bit_end && cnt == BIT_LAST) next = parity_en ? PARITY : STOP;
            PARITY:  next = bit_end ? STOP : PARITY;
            STOP:    if (bit_end) next = pndng ? POP : IDLE;
            default: next = IDLE;
        endcase
    end

    // parity is taken from the word at capture time, since shreg is consumed by shifting
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            baud  <= '0;
            cnt   <= '0;
            shreg <= '0;
            par   <= 1'b0;
        end else begin
            state <= next;
            baud  <= (next != state || bit_end) ? '0 : baud + 1'b1;
            if (state == LOAD) begin
                shreg <= fifo_dout;
                par   <= ^fifo_dout;
                cnt   <= '0;
            end else if (state == DATA && bit_end) begin
                shreg <= shreg >> 1;
                cnt   <= cnt + 1'b1;
            end
        end
    end

    assign pop        = state == POP;
    assign busy       = state != IDLE;
    assign frame_done = state == STOP && bit_end;
    assign tx         = (state == START) ? 1'b0 :
                        (state == DATA)   ? shreg[0] :
                        (state == PARITY) ? par : 1'b1;
endmodule
